// File: rtl/burst_ram_pkg.sv
// Shared definitions for burst RAM initiators and the RAM simulation model:
// command encodings and the master state encoding.
package burst_ram_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4
    } burst_state_t;

endpackage : burst_ram_pkg

// File: rtl/burst_ram_master.sv
// Runs one BURST_COUNT-beat burst on the burst RAM per cache-line request:
// serializes a write line into beats or gathers read beats into a line.
module burst_ram_master
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4,
    parameter int DATA_BITWIDTH  = 64,
    localparam int BEAT_BITWIDTH      = $clog2(BURST_COUNT),
    localparam int LINE_ADDR_BITWIDTH = DEPTH_BITWIDTH - BEAT_BITWIDTH,
    localparam int LINE_BITWIDTH      = BURST_COUNT * DATA_BITWIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    // upstream client
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [LINE_ADDR_BITWIDTH-1:0] req_addr,
    input  logic [LINE_BITWIDTH-1:0]      req_wr_line,
    output logic                          resp_valid,
    output logic [LINE_BITWIDTH-1:0]      resp_rd_line,
    output logic                          protocol_error,
    // burst RAM command interface
    output logic                          cmd,
    output logic                          cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]     addr,
    output logic [DATA_BITWIDTH-1:0]      wr_data,
    output logic [DATA_BITWIDTH/8-1:0]    data_mask,
    input  logic [DATA_BITWIDTH-1:0]      rd_data,
    input  logic                          rd_data_valid,
    input  logic                          busy
);

    localparam logic [BEAT_BITWIDTH-1:0] LAST_BEAT = BEAT_BITWIDTH'(BURST_COUNT - 1);

    burst_state_t                  r_state;
    burst_state_t                  w_next_state;
    logic                          r_write;
    logic [LINE_ADDR_BITWIDTH-1:0] r_line_addr;
    logic [LINE_BITWIDTH-1:0]      r_wr_line;
    logic [LINE_BITWIDTH-1:0]      r_gather;
    logic [LINE_BITWIDTH-1:0]      r_resp_line;
    logic [BEAT_BITWIDTH-1:0]      r_beat;
    logic                          r_protocol_error;

    logic                          w_latch;
    logic                          w_beat_inc;
    logic                          w_store;
    logic [LINE_BITWIDTH-1:0]      w_gather_next;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        cmd_en       = 1'b0;
        resp_valid   = 1'b0;
        w_latch      = 1'b0;
        w_beat_inc   = 1'b0;
        w_store      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_latch      = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!busy) begin
                    cmd_en       = 1'b1;
                    // beat 0 goes out with the command itself
                    w_beat_inc   = r_write;
                    w_next_state = r_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                w_beat_inc = 1'b1;
                if (r_beat == LAST_BEAT) w_next_state = ST_DRAIN;
            end
            ST_READ: begin
                if (rd_data_valid) begin
                    w_store    = 1'b1;
                    w_beat_inc = 1'b1;
                    if (r_beat == LAST_BEAT) w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!busy) begin
                    resp_valid   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_gather_next = r_gather;
        if (w_store) w_gather_next[r_beat*DATA_BITWIDTH +: DATA_BITWIDTH] = rd_data;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_write          <= CMD_READ;
            r_line_addr      <= '0;
            r_wr_line        <= '0;
            r_beat           <= '0;
            r_resp_line      <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_write     <= req_write;
                r_line_addr <= req_addr;
                r_wr_line   <= req_wr_line;
                r_beat      <= '0;
            end else if (w_beat_inc) begin
                r_beat <= r_beat + 1'b1;
            end
            // the response line only changes once a whole read line has arrived
            if (w_store && r_beat == LAST_BEAT) r_resp_line <= w_gather_next;
            if (rd_data_valid && r_state != ST_READ) r_protocol_error <= 1'b1;
        end
    end

    // NOTE: the gather buffer is pure datapath; every slot is overwritten before it is used, so it has no reset.
    always_ff @(posedge clk) begin
        r_gather <= w_gather_next;
    end

    assign cmd            = r_write ? CMD_WRITE : CMD_READ;
    assign addr           = {r_line_addr, BEAT_BITWIDTH'(0)};
    assign wr_data        = r_wr_line[r_beat*DATA_BITWIDTH +: DATA_BITWIDTH];
    assign data_mask      = '0;
    assign resp_rd_line   = r_resp_line;
    assign protocol_error = r_protocol_error;

endmodule : burst_ram_master
